iob_sync_assim_fifo: RTL and testbench
======================================

Name: iob_sync_assim_fifo

Overview:
Single-clock FIFO with independent, asymmetric write and read data widths; either side may be the wider one.
Storage is a narrow-word RAM. Wide-side accesses map to RATIO consecutive narrow words, little-endian: the lowest narrow address goes in the LSBs.
Used between width-mismatched datapaths, e.g. byte stream to 32-bit bus or the reverse, including occupancy tracking and full/empty flow control.

Parameters:
W_DATA_W, 8, write port data width in bits
R_DATA_W, 32, read port data width in bits
ADDR_W, 8, log2 of depth in narrow (min-width) words; must satisfy ADDR_W >= log2(RATIO)
- RATIO = max/min of the two widths; must be a power of two. W_RATIO = W_DATA_W/min width, R_RATIO = R_DATA_W/min width (one of them is 1).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
w_en  input  1  write request
w_data  input  W_DATA_W  write data
w_full  output  1  write side cannot accept one W_DATA_W word
r_en  input  1  read request
r_data  output  R_DATA_W  read data, registered
r_empty  output  1  fewer than one R_DATA_W word stored
level  output  ADDR_W+1  occupancy in narrow words

Behaviour:
- Reset (async assert, synchronous release): wptr=0, rptr=0, level=0, r_data=0, r_empty=1, w_full=0. RAM contents are not reset.
- Pointers are ADDR_W bits and address narrow words.
  - Accepted write: wptr += W_RATIO.
  - Accepted read: rptr += R_RATIO.
  - Both wrap modulo 2^ADDR_W.
- Wide write: narrow word i of w_data (bits (i+1)*min-1 -: min) is stored at wptr+i, for i in 0..W_RATIO-1, all in one cycle.
- Wide read: narrow word i of r_data is taken from rptr+i.
- Accepts:
  - Write accepted iff w_en && !w_full.
  - Read accepted iff r_en && !r_empty.
  - Rejected requests change no state; r_data holds.
- Read latency: r_data is updated on the clock edge that accepts the read and is valid from that edge until the next accepted read. There is no fall-through.
- Flags, combinational from the level register:
  - w_full = (level > 2^ADDR_W - W_RATIO).
  - r_empty = (level < R_RATIO).
- Level update per edge: level_next = level + (wacc ? W_RATIO : 0) - (racc ? R_RATIO : 0). Both may occur in the same cycle.
- Simultaneous read and write are judged on pre-edge flags.
  - A write into an empty FIFO is not readable in the same cycle. It becomes readable next cycle, once level >= R_RATIO.
  - A read on a full FIFO frees space only from the next cycle.
- Same-address read/write in one cycle cannot occur for accepted operations, because the flags prevent overlap of unread data. RAM read-during-write behaviour is don't-care.
- Partial wide word: if level is below R_RATIO (narrow-to-wide case), the data stays stored and r_empty remains 1 until enough narrow words arrive. There is no flush.
- level never exceeds 2^ADDR_W and never goes negative.

Optional Feature:
Macro: IOB_ASSIM_FIFO_ERR_EN
- Defined: adds outputs w_overflow (1) and r_underflow (1).
  - w_overflow sets on w_en && w_full.
  - r_underflow sets on r_en && r_empty.
  - Both flags are sticky and cleared only by rst_n.
- Undefined: the ports do not exist. Illegal requests are silently ignored as above.

Test Plan:
(W=8, R=32, ADDR_W=4 unless stated)
- Reset mid-operation: with level=8, drop rst_n for 1 ns, no clock -> level=0, r_empty=1, w_full=0, r_data=0 immediately.
- Pack order: write 0x11, 0x22, 0x33, 0x44 on 4 cycles, then r_en -> r_data=0x44332211 after that edge. r_empty is 1 until the 4th write edge and 0 after it. level goes 4 -> 0.
- Full and overflow: write 16 bytes -> w_full=1, level=16. A 17th w_en leaves level=16 and data unchanged, and sets w_overflow if ERR_EN. Read all 4 words -> values intact, r_empty=1.
- Wrap-around: run 40 byte writes interleaved with 10 word reads, with reads issued whenever !r_empty -> every read word equals the 4 bytes written, in order, across pointer wrap.
- Simultaneous read and write: at level=4, w_en and r_en in the same cycle -> level=1 and r_data = the oldest 4 bytes. An r_en on the next cycle is rejected (r_empty=1) and sets r_underflow if ERR_EN.
- Reversed ratio: W=32, R=8, ADDR_W=3. Write 0xA1B2C3D4 -> 4 reads return 0xD4, 0xC3, 0xB2, 0xA1. At level=5, w_full=1 (5 > 8-4).

Source files
------------

// File: rtl/iob_sync_assim_fifo_if.sv
// Handshake bundle for iob_sync_assim_fifo: write port, read port and occupancy.
// The error flags exist only when IOB_ASSIM_FIFO_ERR_EN is defined.
interface iob_sync_assim_fifo_if #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 8
);

  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic [ADDR_W:0]     level;
`ifdef IOB_ASSIM_FIFO_ERR_EN
  logic                w_overflow;
  logic                r_underflow;
`endif

  modport master (
    output w_en, w_data, r_en,
    input  w_full, r_data, r_empty, level
`ifdef IOB_ASSIM_FIFO_ERR_EN
    , input w_overflow, r_underflow
`endif
  );

  modport slave (
    input  w_en, w_data, r_en,
    output w_full, r_data, r_empty, level
`ifdef IOB_ASSIM_FIFO_ERR_EN
    , output w_overflow, r_underflow
`endif
  );

endinterface

// File: rtl/iob_sync_assim_fifo.sv
// Single-clock FIFO with asymmetric write/read widths over a narrow-word RAM.
// Optional sticky overflow/underflow flags: define IOB_ASSIM_FIFO_ERR_EN.
module iob_sync_assim_fifo #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  iob_sync_assim_fifo_if.slave bus
);

  localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int W_RATIO = W_DATA_W / MIN_W;
  localparam int R_RATIO = R_DATA_W / MIN_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LVL_W   = ADDR_W + 1;

  localparam logic [LVL_W-1:0]  FULL_THR = LVL_W'(DEPTH - W_RATIO);
  localparam logic [LVL_W-1:0]  R_STEP   = LVL_W'(R_RATIO);
  localparam logic [LVL_W-1:0]  W_STEP   = LVL_W'(W_RATIO);
  // A ratio equal to the depth wraps to zero, which is the correct pointer step.
  localparam logic [ADDR_W-1:0] W_PSTEP  = ADDR_W'(W_RATIO);
  localparam logic [ADDR_W-1:0] R_PSTEP  = ADDR_W'(R_RATIO);

  logic [MIN_W-1:0]    mem [DEPTH];

  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [R_DATA_W-1:0] r_data_q, r_data_d;
  logic [R_DATA_W-1:0] rd_word;

  logic w_full;
  logic r_empty;
  logic wacc;
  logic racc;

  always_comb begin
    w_full  = (level_q > FULL_THR);
    r_empty = (level_q < R_STEP);
    wacc    = bus.w_en && !w_full;
    racc    = bus.r_en && !r_empty;
  end

  // Gather R_RATIO narrow words starting at rptr, lowest address in the LSBs.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < R_RATIO; i++) begin
      rd_word[i*MIN_W +: MIN_W] = mem[rptr_q + ADDR_W'(i)];
    end
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    r_data_d = r_data_q;
    if (wacc) begin
      wptr_d = wptr_q + W_PSTEP;
    end
    if (racc) begin
      rptr_d   = rptr_q + R_PSTEP;
      r_data_d = rd_word;
    end
    level_d = level_q + (wacc ? W_STEP : '0) - (racc ? R_STEP : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      r_data_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      r_data_q <= r_data_d;
    end
  end

  // Storage is not reset; the level register alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wacc) begin
      for (int i = 0; i < W_RATIO; i++) begin
        mem[wptr_q + ADDR_W'(i)] <= bus.w_data[i*MIN_W +: MIN_W];
      end
    end
  end

  assign bus.w_full  = w_full;
  assign bus.r_empty = r_empty;
  assign bus.level   = level_q;
  assign bus.r_data  = r_data_q;

`ifdef IOB_ASSIM_FIFO_ERR_EN
  logic w_overflow_q, w_overflow_d;
  logic r_underflow_q, r_underflow_d;

  always_comb begin
    w_overflow_d  = w_overflow_q  | (bus.w_en && w_full);
    r_underflow_d = r_underflow_q | (bus.r_en && r_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_overflow_q  <= 1'b0;
      r_underflow_q <= 1'b0;
    end else begin
      w_overflow_q  <= w_overflow_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  assign bus.w_overflow  = w_overflow_q;
  assign bus.r_underflow = r_underflow_q;
`endif

endmodule

// File: tb/tb_iob_sync_assim_fifo.sv
// Bench for iob_sync_assim_fifo: vector table, hand sequences, and a random run
// against a byte-queue model; a second instance covers the wide-write/narrow-read case.
module tb_iob_sync_assim_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iob_sync_assim_fifo_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) bus  ();
  iob_sync_assim_fifo_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(3)) bus2 ();

  iob_sync_assim_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  iob_sync_assim_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(3)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
    bus.w_en = we; bus.w_data = wd; bus.r_en = re;
    @(posedge clk); #1;
    bus.w_en = 1'b0; bus.r_en = 1'b0;
  endtask

  task automatic cyc2(input logic we, input logic [31:0] wd, input logic re);
    bus2.w_en = we; bus2.w_data = wd; bus2.r_en = re;
    @(posedge clk); #1;
    bus2.w_en = 1'b0; bus2.r_en = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        re;
    logic [4:0]  lvl;
    logic        emp;
    logic        full;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  // Reference model: a plain queue of stored bytes.
  logic [7:0]  mq [$];
  logic [31:0] exp_rd;

  task automatic model_cycle(input logic we, input logic [7:0] wd, input logic re,
                             output logic racc_o);
    logic m_wacc, m_racc;
    m_wacc = we && (mq.size() + 1 <= 16);
    m_racc = re && (mq.size() >= 4);
    cyc(we, wd, re);
    if (m_racc) begin
      for (int k = 0; k < 4; k++) exp_rd[k*8 +: 8] = mq.pop_front();
    end
    if (m_wacc) mq.push_back(wd);
    racc_o = m_racc;
    chk("m_level", bus.level, mq.size());
    chk("m_empty", bus.r_empty, mq.size() < 4);
    chk("m_full",  bus.w_full,  mq.size() > 15);
    chk("m_rdata", bus.r_data,  exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic racc;
    int   nreads;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 5'd4, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 32'h44332211};
    tbl[5]  = '{1'b1, 8'h55, 1'b0, 5'd1, 1'b1, 1'b0, 32'h44332211};
    tbl[6]  = '{1'b1, 8'h66, 1'b0, 5'd2, 1'b1, 1'b0, 32'h44332211};
    tbl[7]  = '{1'b1, 8'h77, 1'b0, 5'd3, 1'b1, 1'b0, 32'h44332211};
    tbl[8]  = '{1'b1, 8'h88, 1'b0, 5'd4, 1'b0, 1'b0, 32'h44332211};
    tbl[9]  = '{1'b1, 8'h99, 1'b1, 5'd1, 1'b1, 1'b0, 32'h88776655};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 1'b0, 32'h88776655};

    bus.w_en = 1'b0; bus.w_data = '0; bus.r_en = 1'b0;
    bus2.w_en = 1'b0; bus2.w_data = '0; bus2.r_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.r_empty, 1);
    chk("rst_full",  bus.w_full, 0);
    chk("rst_rdata", bus.r_data, 0);
    chk("rst2_empty", bus2.r_empty, 1);

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].we, tbl[i].wd, tbl[i].re);
      chk($sformatf("tbl%0d_level", i), bus.level,   tbl[i].lvl);
      chk($sformatf("tbl%0d_empty", i), bus.r_empty, tbl[i].emp);
      chk($sformatf("tbl%0d_full",  i), bus.w_full,  tbl[i].full);
      chk($sformatf("tbl%0d_rdata", i), bus.r_data,  tbl[i].rd);
    end
`ifdef IOB_ASSIM_FIFO_ERR_EN
    chk("underflow_set", bus.r_underflow, 1);
    chk("overflow_clr",  bus.w_overflow,  0);
`endif

    // Fill to 8 bytes, then assert reset between edges.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("pre_rst_level", bus.level, 8);
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", bus.level, 0);
    chk("async_rst_empty", bus.r_empty, 1);
    chk("async_rst_full",  bus.w_full, 0);
    chk("async_rst_rdata", bus.r_data, 0);
`ifdef IOB_ASSIM_FIFO_ERR_EN
    chk("async_rst_uflow", bus.r_underflow, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("fill_level", bus.level, 16);
    chk("fill_full",  bus.w_full, 1);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_level", bus.level, 16);
    chk("ovf_full",  bus.w_full, 1);
`ifdef IOB_ASSIM_FIFO_ERR_EN
    chk("overflow_set", bus.w_overflow, 1);
`endif
    for (int w = 0; w < 4; w++) begin
      logic [31:0] e;
      for (int k = 0; k < 4; k++) e[k*8 +: 8] = 8'hA0 + 8'(w*4 + k);
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d_rdata", w), bus.r_data, e);
      chk($sformatf("drain%0d_full", w), bus.w_full, 0);
    end
    chk("drain_empty", bus.r_empty, 1);
    chk("drain_level", bus.level, 0);

    // Model-checked runs: byte stream with reads on every non-empty cycle, then random.
    mq.delete();
    exp_rd = 32'hAFAEADAC;
    nreads = 0;
    for (int i = 0; i < 40; i++) begin
      model_cycle(1'b1, 8'($urandom), !bus.r_empty, racc);
      if (racc) nreads++;
    end
    for (int i = 0; i < 8 && !bus.r_empty; i++) begin
      model_cycle(1'b0, 8'h00, 1'b1, racc);
      if (racc) nreads++;
    end
    chk("wrap_reads", nreads, 10);
    for (int i = 0; i < 500; i++) begin
      logic we, re;
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 40);
      model_cycle(we, 8'($urandom), re, racc);
    end

    // Wide write, narrow read.
    chk("r2_rst_level", bus2.level, 0);
    cyc2(1'b1, 32'hA1B2C3D4, 1'b0);
    chk("r2_w1_level", bus2.level, 4);
    chk("r2_w1_full",  bus2.w_full, 0);
    chk("r2_w1_empty", bus2.r_empty, 0);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd0", bus2.r_data, 8'hD4);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd1", bus2.r_data, 8'hC3);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd2", bus2.r_data, 8'hB2);
    cyc2(1'b1, 32'h11223344, 1'b0);
    chk("r2_l5_level", bus2.level, 5);
    chk("r2_l5_full",  bus2.w_full, 1);
    cyc2(1'b1, 32'hDEADBEEF, 1'b0);
    chk("r2_rej_level", bus2.level, 5);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd3", bus2.r_data, 8'hA1);
    chk("r2_l4_full", bus2.w_full, 0);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd4", bus2.r_data, 8'h44);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd5", bus2.r_data, 8'h33);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd6", bus2.r_data, 8'h22);
    cyc2(1'b0, 32'h0, 1'b1); chk("r2_rd7", bus2.r_data, 8'h11);
    chk("r2_end_empty", bus2.r_empty, 1);
    chk("r2_end_level", bus2.level, 0);
    cyc2(1'b0, 32'h0, 1'b1);
    chk("r2_hold_rdata", bus2.r_data, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
